// File: rtl/frac_n_dsm_ctrl.sv
// Fractional-N divide-modulus generator: channel map, MASH 1-1-1
// modulator with optional LFSR dither, and a handshaked config update.
module frac_n_dsm_ctrl #(
  parameter int CH_W   = 7,
  parameter int INT_W  = 5,
  parameter int FRAC_W = 24,
  parameter logic [INT_W+FRAC_W-1:0] BASE = {5'd20, 24'd0},
  parameter logic [FRAC_W+INT_W-1:0] STEP = 29'h0200000,
  parameter int HOLD   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CH_W-1:0]   i_ch_in,
  input  logic [1:0]        i_order_in,
  input  logic              i_dither_in,
  input  logic              i_clr_on_chg,
  input  logic              i_ch_valid,
  output logic              o_ch_ready,
  output logic [INT_W:0]    o_out_data
);

  localparam int WW = INT_W + FRAC_W;
  localparam int HW = $clog2(HOLD + 1);
  localparam int SW = INT_W + 3;
  localparam logic [INT_W-1:0] BASE_INT = BASE[WW-1:FRAC_W];
  localparam logic [FRAC_W-1:0] BASE_FRAC = BASE[FRAC_W-1:0];
  localparam logic signed [SW-1:0] OMAX = SW'((1 << (INT_W + 1)) - 1);

  logic [HW-1:0]     r_hold;
  logic [INT_W-1:0]  r_int;
  logic [INT_W-1:0]  r_int_p;
  logic [FRAC_W-1:0] r_frac;
  logic [1:0]        r_order;
  logic              r_dith;
  logic [FRAC_W-1:0] r_acc1, r_acc2, r_acc3;
  logic              r_c1, r_c2, r_c3;
  logic              r_c2d, r_c3d, r_c3dd;
  logic [15:0]       r_lfsr;

  logic              w_accept;
  logic              w_clr;
  logic [WW-1:0]     w_word;
  logic              w_d;
  logic              w_fb;
  logic [FRAC_W:0]   w_s1, w_s2, w_s3;
  logic signed [3:0] w_c1, w_c2, w_c2d, w_c3, w_c3d, w_c3dd;
  logic signed [3:0] w_y;
  logic signed [SW-1:0] w_sum;
  logic [INT_W:0]    w_out;

  assign o_ch_ready = (r_hold == '0);
  assign w_accept   = i_ch_valid & o_ch_ready;
  assign w_clr      = w_accept & i_clr_on_chg;
  assign w_word     = BASE + STEP * WW'(i_ch_in);

  assign w_d  = r_dith & r_lfsr[0];
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Chained stages: each adds the fresh sum of the previous one
  assign w_s1 = {1'b0, r_acc1} + {1'b0, r_frac} + (FRAC_W+1)'(w_d);
  assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[FRAC_W-1:0]};
  assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[FRAC_W-1:0]};

  assign w_c1   = {3'b000, r_c1};
  assign w_c2   = {3'b000, r_c2};
  assign w_c2d  = {3'b000, r_c2d};
  assign w_c3   = {3'b000, r_c3};
  assign w_c3d  = {3'b000, r_c3d};
  assign w_c3dd = {3'b000, r_c3dd};

  always_comb begin
    w_y = '0;
    unique case (r_order)
      2'd0: w_y = '0;
      2'd1: w_y = w_c1;
      2'd2: w_y = w_c1 + w_c2 - w_c2d;
      2'd3: w_y = w_c1 + w_c2 - w_c2d
                + w_c3 - (w_c3d <<< 1) + w_c3dd;
    endcase
  end

  always_comb begin
    w_sum = $signed({3'b000, r_int_p})
          + $signed({{(SW-4){w_y[3]}}, w_y});
    w_out = w_sum[INT_W:0];
    if (w_sum < 0) begin
      w_out = '0;
    end else if (w_sum > OMAX) begin
      w_out = OMAX[INT_W:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold  <= '0;
      r_int   <= BASE_INT;
      r_frac  <= BASE_FRAC;
      r_order <= 2'd3;
      r_dith  <= 1'b0;
    end else if (w_accept) begin
      r_hold  <= HW'(HOLD);
      r_int   <= w_word[WW-1:FRAC_W];
      r_frac  <= w_word[FRAC_W-1:0];
      r_order <= i_order_in;
      r_dith  <= i_dither_in;
    end else if (r_hold != '0) begin
      r_hold  <= r_hold - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
      r_c1   <= 1'b0;
      r_c2   <= 1'b0;
      r_c3   <= 1'b0;
      r_c2d  <= 1'b0;
      r_c3d  <= 1'b0;
      r_c3dd <= 1'b0;
    end else if (w_clr) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_acc3 <= '0;
      r_c1   <= 1'b0;
      r_c2   <= 1'b0;
      r_c3   <= 1'b0;
      r_c2d  <= 1'b0;
      r_c3d  <= 1'b0;
      r_c3dd <= 1'b0;
    end else begin
      r_acc1 <= w_s1[FRAC_W-1:0];
      r_acc2 <= w_s2[FRAC_W-1:0];
      r_acc3 <= w_s3[FRAC_W-1:0];
      r_c1   <= w_s1[FRAC_W];
      r_c2   <= w_s2[FRAC_W];
      r_c3   <= w_s3[FRAC_W];
      r_c2d  <= r_c2;
      r_c3d  <= r_c3;
      r_c3dd <= r_c3d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr     <= 16'hACE1;
      r_int_p    <= BASE_INT;
      o_out_data <= '0;
    end else begin
      r_lfsr     <= {w_fb, r_lfsr[15:1]};
      r_int_p    <= r_int;
      o_out_data <= w_out;
    end
  end

endmodule
